// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic (write and read sides).
// Functions work on a 32-bit container so any pointer width up to 32 bits
// can use them; callers cast in and slice the result back out.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits of a narrower pointer
  // leave the result unchanged.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/pointer_synchronizer.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Ports:
//   clock   - destination-domain clock
//   reset_n - synchronous active-low reset, clears every stage
//   i_data  - gray pointer from the source-domain flop
//   o_data  - pointer after STAGES flops
module pointer_synchronizer #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= i_data;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_data = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_write_port.sv
// Write-side controller of a dual-clock FIFO. Owns the write pointer, drives
// the RAM write port, publishes the gray write pointer to the read domain and
// derives full / almost_full / fill level from the synchronised read pointer.
// Ports:
//   clock, reset_n        - write-domain clock, synchronous active-low reset
//   write_enable/_data    - write request and word
//   read_pointer_gray     - read pointer (gray) from the read-domain flop
//   overflow_clear        - clears the sticky overflow flag
//   memory_write_*        - registered RAM write strobe/address/data
//   write_pointer_gray    - registered gray write pointer for the read domain
//   full, almost_full     - registered status flags
//   write_level           - registered fill count, 0..DATA_DEPTH
//   overflow              - sticky flag: write attempted while full
module async_fifo_write_port
  import async_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH        = 16,
  parameter  int DATA_DEPTH        = 4096,
  parameter  int SYNC_STAGES       = 2,
  parameter  int ALMOST_FULL_LEVEL = DATA_DEPTH - 4,
  localparam int AW                = $clog2(DATA_DEPTH),
  localparam int PW                = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [PW-1:0]         read_pointer_gray,
  input  logic                  overflow_clear,
  output logic                  memory_write_enable,
  output logic [AW-1:0]         memory_write_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  output logic [PW-1:0]         write_pointer_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [PW-1:0]         write_level,
  output logic                  overflow
);

  localparam logic [PW-1:0] DEPTH_W = PW'(DATA_DEPTH);
  localparam logic [PW-1:0] AFULL_W = PW'(ALMOST_FULL_LEVEL);

  logic [PW-1:0] r_wr_ptr_bin;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_sync_gray;
  logic [PW-1:0] w_rd_sync_bin;
  logic [PW-1:0] w_level_next;
  logic          w_accept;

  pointer_synchronizer #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_data  (read_pointer_gray),
    .o_data  (w_rd_sync_gray)
  );

  assign w_rd_sync_bin = PW'(gray2bin(ptr_word_t'(w_rd_sync_gray)));

  // Gate on the registered full flag so the accept path stays short.
  assign w_accept      = write_enable && !full;
  assign w_wr_ptr_next = r_wr_ptr_bin + PW'(w_accept);
  // The extra pointer bit makes DATA_DEPTH representable, so the modulo
  // difference distinguishes full from empty.
  assign w_level_next  = w_wr_ptr_next - w_rd_sync_bin;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr_bin         <= '0;
      write_pointer_gray   <= '0;
      write_level          <= '0;
      full                 <= 1'b0;
      almost_full          <= 1'b0;
      overflow             <= 1'b0;
      memory_write_enable  <= 1'b0;
      memory_write_address <= '0;
      memory_write_data    <= '0;
    end else begin
      r_wr_ptr_bin        <= w_wr_ptr_next;
      write_pointer_gray  <= PW'(bin2gray(ptr_word_t'(w_wr_ptr_next)));
      write_level         <= w_level_next;
      full                <= (w_level_next == DEPTH_W);
      almost_full         <= (w_level_next >= AFULL_W);
      memory_write_enable <= w_accept;
      if (w_accept) begin
        memory_write_address <= r_wr_ptr_bin[AW-1:0];
        memory_write_data    <= write_data;
      end
      // A new overflow event wins over a same-cycle clear.
      if (write_enable && full) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_write_port.sv
module tb_async_fifo_write_port;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [PW-1:0] read_pointer_gray;
  logic          overflow_clear;
  logic          memory_write_enable;
  logic [AW-1:0] memory_write_address;
  logic [DW-1:0] memory_write_data;
  logic [PW-1:0] write_pointer_gray;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] write_level;
  logic          overflow;

  always #5 clock = ~clock;

  async_fifo_write_port #(
    .DATA_WIDTH        (DW),
    .DATA_DEPTH        (DEPTH),
    .SYNC_STAGES       (2),
    .ALMOST_FULL_LEVEL (6)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .write_enable         (write_enable),
    .write_data           (write_data),
    .read_pointer_gray    (read_pointer_gray),
    .overflow_clear       (overflow_clear),
    .memory_write_enable  (memory_write_enable),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .write_pointer_gray   (write_pointer_gray),
    .full                 (full),
    .almost_full          (almost_full),
    .write_level          (write_level),
    .overflow             (overflow)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  wr_ptr = 0;
  int  rd_ptr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] g4(input int b);
    logic [PW-1:0] x;
    x = b[PW-1:0];
    return x ^ (x >> 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive a write that the bench expects to be accepted.
  task automatic drive_wr(input logic [DW-1:0] d);
    wr_t e;
    e.addr = AW'(wr_ptr % DEPTH);
    e.data = d;
    sb_q.push_back(e);
    wr_ptr = (wr_ptr + 1) % 16;
    write_enable = 1'b1;
    write_data   = d;
  endtask

  task automatic set_rd(input int b);
    rd_ptr = b % 16;
    read_pointer_gray = g4(rd_ptr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mwe"},  32'(memory_write_enable),  32'd0);
    check({tag, "_maddr"}, 32'(memory_write_address), 32'd0);
    check({tag, "_mdata"}, 32'(memory_write_data),    32'd0);
    check({tag, "_wpg"},  32'(write_pointer_gray),   32'd0);
    check({tag, "_full"}, 32'(full),                 32'd0);
    check({tag, "_afull"}, 32'(almost_full),         32'd0);
    check({tag, "_level"}, 32'(write_level),         32'd0);
    check({tag, "_ovf"},  32'(overflow),             32'd0);
  endtask

  always @(negedge clock) begin : sb_mon
    wr_t e;
    if (memory_write_enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_strobe", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("mem_addr", 32'(memory_write_address), 32'(e.addr));
        check("mem_data", 32'(memory_write_data),    32'(e.data));
      end
    end
  end

  initial begin
    logic [PW-1:0] prev_g;
    reset_n = 1'b0;
    write_enable = 1'b0;
    write_data = '0;
    read_pointer_gray = '0;
    overflow_clear = 1'b0;
    step();
    step();
    check_all_zero("rst");
    reset_n = 1'b1;

    // Fill from empty
    for (int i = 0; i < 8; i++) begin
      drive_wr(16'(16'hA0 + i));
      step();
      check("fill_level", 32'(write_level), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'((i + 1) >= 6));
      check("fill_full",  32'(full),        32'((i + 1) == 8));
      check("fill_wpg",   32'(write_pointer_gray), 32'(g4(i + 1)));
    end

    // Write while full is dropped
    write_enable = 1'b1;
    write_data   = 16'hA8;
    step();
    check("drop_ovf",   32'(overflow),    32'd1);
    check("drop_level", 32'(write_level), 32'd8);
    check("drop_wpg",   32'(write_pointer_gray), 32'(g4(8)));
    write_enable = 1'b0;
    step();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Clear together with a new overflow: set wins
    write_enable   = 1'b1;
    overflow_clear = 1'b1;
    step();
    check("ovf_set_wins", 32'(overflow), 32'd1);
    write_enable = 1'b0;
    step();
    check("ovf_cleared", 32'(overflow), 32'd0);
    overflow_clear = 1'b0;

    // Read pointer 0 -> 3: full drops SYNC_STAGES+1 clocks later
    set_rd(3);
    step();
    check("full_lag1", 32'(full), 32'd1);
    step();
    check("full_lag2", 32'(full), 32'd1);
    step();
    check("full_lag3",  32'(full),        32'd0);
    check("level_rd3",  32'(write_level), 32'd5);
    check("afull_rd3",  32'(almost_full), 32'd0);

    // Almost-full boundary
    drive_wr(16'hB0);
    step();
    write_enable = 1'b0;
    check("af_set",    32'(almost_full), 32'd1);
    check("af_level6", 32'(write_level), 32'd6);
    set_rd(4);
    step();
    step();
    check("af_hold", 32'(write_level), 32'd6);
    step();
    check("af_clr",    32'(almost_full), 32'd0);
    check("af_level5", 32'(write_level), 32'd5);

    // 16 writes with read tracking: address and pointer wrap
    for (int k = 0; k < 16; k++) begin
      prev_g = write_pointer_gray;
      drive_wr(16'(16'hD0 + k));
      set_rd(rd_ptr + 1);
      step();
      check("wrap_onebit", 32'($countones(prev_g ^ write_pointer_gray)), 32'd1);
      check("wrap_wpg",    32'(write_pointer_gray), 32'(g4(wr_ptr)));
      check("wrap_nofull", 32'(full), 32'd0);
    end
    write_enable = 1'b0;
    set_rd(wr_ptr);
    step();
    step();
    step();
    check("drain_level", 32'(write_level), 32'd0);

    // Reset mid-burst at level 5
    for (int i = 0; i < 5; i++) begin
      drive_wr(16'(16'hE0 + i));
      step();
    end
    check("pre_rst_level", 32'(write_level), 32'd5);
    write_enable      = 1'b1;
    write_data        = 16'hEE;
    reset_n           = 1'b0;
    read_pointer_gray = '0;
    step();
    check_all_zero("midrst");
    reset_n = 1'b1;
    wr_ptr  = 0;
    rd_ptr  = 0;
    drive_wr(16'hC0);
    step();
    write_enable = 1'b0;
    check("post_rst_level", 32'(write_level), 32'd1);
    check("post_rst_wpg",   32'(write_pointer_gray), 32'(g4(1)));
    step();
    step();
    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_fifo_write_port.md
ASYNC_FIFO_WRITE_PORT -- requirements
Module: async_fifo_write_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 4096, word count; power of two, >= 4; AW = $clog2(DATA_DEPTH).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, read-pointer synchroniser depth; >= 2.
REQ-004 SHALL have parameter ALMOST_FULL_LEVEL, default DATA_DEPTH-4, almost_full threshold; 1..DATA_DEPTH.
REQ-005 SHALL have port clock  input  1  write-domain clock.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port write_enable  input  1  write request.
REQ-008 SHALL have port write_data  input  DATA_WIDTH  write word.
REQ-009 SHALL have port read_pointer_gray  input  AW+1  read pointer, gray, read-domain flop output.
REQ-010 SHALL have port overflow_clear  input  1  clears overflow.
REQ-011 SHALL have port memory_write_enable  output  1  RAM write strobe.
REQ-012 SHALL have port memory_write_address  output  AW  RAM address.
REQ-013 SHALL have port memory_write_data  output  DATA_WIDTH  RAM data.
REQ-014 SHALL have port write_pointer_gray  output  AW+1  write pointer, gray, to read domain.
REQ-015 SHALL have port full  output  1  no free entry.
REQ-016 SHALL have port almost_full  output  1  level >= ALMOST_FULL_LEVEL.
REQ-017 SHALL have port write_level  output  AW+1  write-side fill count, 0..DATA_DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky write-while-full error.

Function
REQ-019 Write pointer SHALL be AW+1-bit binary, incrementing modulo 2^(AW+1); address = low AW bits.
REQ-020 read_pointer_gray SHALL pass through SYNC_STAGES flops on clock, then convert gray-to-binary (rd_sync).
REQ-021 Accept = write_enable && !full (registered full); accepted write SHALL advance the pointer by 1.
REQ-022 Accepted write SHALL drive memory_write_enable=1, memory_write_address=old pointer low bits, memory_write_data=write_data, all one cycle later (latency 1); otherwise memory_write_enable=0.
REQ-023 write_pointer_gray SHALL be a flop loaded with bin2gray(next pointer), never combinational; exactly one bit changes per accepted write.
REQ-024 level_next = next pointer - rd_sync modulo 2^(AW+1); write_level, full (level_next == DATA_DEPTH), almost_full (level_next >= ALMOST_FULL_LEVEL) SHALL all be registered from it.
REQ-025 Write filling the last entry SHALL assert full in the following cycle; no entry SHALL be overwritten.
REQ-026 full deassertion SHALL be pessimistic: SYNC_STAGES+1 clocks after read_pointer_gray changes.
REQ-027 write_enable while full SHALL be dropped (no strobe, no pointer move) and set overflow next cycle.
REQ-028 overflow SHALL clear on overflow_clear; simultaneous set and clear SHALL leave overflow=1.
REQ-029 write_level SHALL never exceed DATA_DEPTH.

Reset
REQ-030 With reset_n=0 at a clock edge, pointer, synchroniser flops, write_pointer_gray, write_level, full, almost_full, overflow, memory_write_enable, memory_write_address, memory_write_data SHALL be 0 next cycle.
REQ-031 Reset mid-operation SHALL discard pending contents; read domain SHALL be reset in the same reset window (system requirement).

Structure
REQ-032 Package async_fifo_pkg SHALL hold bin2gray and gray2bin functions, parameter-width agnostic.
REQ-033 Synchroniser SHALL be sub-module pointer_synchronizer (params WIDTH, STAGES), reusable by the read controller.

Verification (DATA_DEPTH=8, SYNC_STAGES=2, ALMOST_FULL_LEVEL=6)
REQ-034 Reset, read_pointer_gray=0, 8 back-to-back writes of 0xA0..0xA7 -> addresses 0..7, data A0..A7, full=1 cycle after 8th, write_level=8; 9th write dropped, overflow=1.
REQ-035 From full, read_pointer_gray 0 -> 4'b0010 (binary 3) -> full=0 exactly 3 cycles later, write_level=5.
REQ-036 16 writes with read tracking -> address wraps 7->0, pointer 15->0, write_pointer_gray single-bit change every write.
REQ-037 Level 5, one write -> almost_full=1 and write_level=6 next cycle; level 6 -> 5 after read -> almost_full=0.
REQ-038 overflow_clear with write-while-full same cycle -> overflow stays 1; overflow_clear alone -> 0 next cycle.
REQ-039 reset_n=0 at level 5 mid-burst -> next cycle all outputs 0, next write to address 0.
